id_ex_reg: RTL

ID/EX pipeline register for the pipelined MIPS core. It captures the decode-stage bundle on each rising edge: register-file read data, immediate, destination and control. It then presents that bundle to the execute stage. The block also owns load-use hazard detection, branch-flush bubbling, downstream-stall hold, and write-back refresh of held operands. It sits between `reg_file` (operands valid after its negedge read) and the ALU/forwarding logic.

---
 rtl/id_ex_reg_pkg.sv | 16 +
 rtl/id_ex_reg_if.sv | 63 ++++++
 rtl/id_ex_reg_load_use_detect.sv | 26 ++
 rtl/id_ex_reg.sv | 137 +++++++++++++
 4 files changed

// File: rtl/id_ex_reg_pkg.sv
// Shared widths and select encoding for the ID/EX pipeline register.
// Imported by the interface, hazard detector and register.
package id_ex_reg_pkg;

  localparam int DATA_W_D  = 32;
  localparam int ADDR_W_D  = 5;
  localparam int ALUOP_W_D = 4;
  localparam int PERF_W_D  = 16;

  typedef enum logic [1:0] {
    SEL_HOLD,
    SEL_BUBBLE,
    SEL_LOAD
  } sel_e;

endpackage

// File: rtl/id_ex_reg_if.sv
// Decode-to-execute bundle: id_* driven by decode, ex_* by the
// pipeline register.
interface id_ex_reg_if
  import id_ex_reg_pkg::*;
#(
  parameter int DATA_W  = DATA_W_D,
  parameter int ADDR_W  = ADDR_W_D,
  parameter int ALUOP_W = ALUOP_W_D
);

  logic               id_valid;
  logic [ADDR_W-1:0]  id_rs;
  logic [ADDR_W-1:0]  id_rt;
  logic [ADDR_W-1:0]  id_rd;
  logic [DATA_W-1:0]  id_rs_data;
  logic [DATA_W-1:0]  id_rt_data;
  logic [DATA_W-1:0]  id_imm;
  logic [ALUOP_W-1:0] id_alu_op;
  logic               id_write_reg;
  logic               id_mem_read;
  logic               id_mem_write;
  logic               id_mem_to_reg;

  logic               ex_valid;
  logic [ADDR_W-1:0]  ex_rs;
  logic [ADDR_W-1:0]  ex_rt;
  logic [ADDR_W-1:0]  ex_rd;
  logic [DATA_W-1:0]  ex_rs_data;
  logic [DATA_W-1:0]  ex_rt_data;
  logic [DATA_W-1:0]  ex_imm;
  logic [ALUOP_W-1:0] ex_alu_op;
  logic               ex_write_reg;
  logic               ex_mem_read;
  logic               ex_mem_write;
  logic               ex_mem_to_reg;

  modport master (
    output id_valid, id_rs, id_rt, id_rd,
    output id_rs_data, id_rt_data, id_imm,
    output id_alu_op, id_write_reg,
    output id_mem_read, id_mem_write,
    output id_mem_to_reg,
    input  ex_valid, ex_rs, ex_rt, ex_rd,
    input  ex_rs_data, ex_rt_data, ex_imm,
    input  ex_alu_op, ex_write_reg,
    input  ex_mem_read, ex_mem_write,
    input  ex_mem_to_reg
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd,
    input  id_rs_data, id_rt_data, id_imm,
    input  id_alu_op, id_write_reg,
    input  id_mem_read, id_mem_write,
    input  id_mem_to_reg,
    output ex_valid, ex_rs, ex_rt, ex_rd,
    output ex_rs_data, ex_rt_data, ex_imm,
    output ex_alu_op, ex_write_reg,
    output ex_mem_read, ex_mem_write,
    output ex_mem_to_reg
  );

endinterface

// File: rtl/id_ex_reg_load_use_detect.sv
// Load-use hazard compare: a load in the later slot whose
// destination feeds either source of the earlier slot.
module load_use_detect
  import id_ex_reg_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_D
) (
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [ADDR_W-1:0] ex_rd,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  output logic              hazard
);

  logic src_hit;

  assign src_hit = (id_rs == ex_rd) | (id_rt == ex_rd);

  // r0 is hardwired, so a load into it never blocks
  assign hazard = ex_valid & ex_mem_read
                & (ex_rd != '0)
                & id_valid & src_hit;

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use bubbling, flush,
// downstream hold and write-back refresh of held operands.
module id_ex_reg
  import id_ex_reg_pkg::*;
#(
  parameter int DATA_W  = DATA_W_D,
  parameter int ADDR_W  = ADDR_W_D,
  parameter int ALUOP_W = ALUOP_W_D,
  parameter int PERF_W  = PERF_W_D
) (
  input  logic              clk,
  input  logic              rst_n,
  id_ex_reg_if.slave        bus,
  input  logic              flush_i,
  input  logic              ex_stall_i,
  input  logic              wb_write_reg,
  input  logic [ADDR_W-1:0] wb_reg_des,
  input  logic [DATA_W-1:0] wb_reg_data,
  output logic              id_stall_o,
  output logic [PERF_W-1:0] perf_bubbles
);

  typedef struct packed {
    logic               valid;
    logic [ADDR_W-1:0]  rs;
    logic [ADDR_W-1:0]  rt;
    logic [ADDR_W-1:0]  rd;
    logic [DATA_W-1:0]  rs_data;
    logic [DATA_W-1:0]  rt_data;
    logic [DATA_W-1:0]  imm;
    logic [ALUOP_W-1:0] alu_op;
    logic               write_reg;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
  } id_ex_t;

  id_ex_t id_b;
  id_ex_t ex_q;
  id_ex_t ex_d;
  sel_e   sel;
  logic   hazard;
  logic   rs_hit;
  logic   rt_hit;
  logic   wb_live;

  assign id_b = '{
    valid:      bus.id_valid,
    rs:         bus.id_rs,
    rt:         bus.id_rt,
    rd:         bus.id_rd,
    rs_data:    bus.id_rs_data,
    rt_data:    bus.id_rt_data,
    imm:        bus.id_imm,
    alu_op:     bus.id_alu_op,
    write_reg:  bus.id_write_reg,
    mem_read:   bus.id_mem_read,
    mem_write:  bus.id_mem_write,
    mem_to_reg: bus.id_mem_to_reg
  };

  load_use_detect #(
    .ADDR_W(ADDR_W)
  ) u_lud (
    .ex_valid   (ex_q.valid),
    .ex_mem_read(ex_q.mem_read),
    .ex_rd      (ex_q.rd),
    .id_valid   (bus.id_valid),
    .id_rs      (bus.id_rs),
    .id_rt      (bus.id_rt),
    .hazard     (hazard)
  );

  // a taken branch squashes the dependent op, so no stall needed
  assign id_stall_o = ex_stall_i | (hazard & ~flush_i);

  always_comb begin
    sel = SEL_LOAD;
    unique case (1'b1)
      ex_stall_i:
        sel = SEL_HOLD;
      !ex_stall_i && (flush_i || hazard):
        sel = SEL_BUBBLE;
      default:
        sel = SEL_LOAD;
    endcase
  end

  assign wb_live = ex_q.valid & wb_write_reg
                 & (wb_reg_des != '0);
  assign rs_hit  = wb_live & (wb_reg_des == ex_q.rs);
  assign rt_hit  = wb_live & (wb_reg_des == ex_q.rt);

  always_comb begin
    ex_d = ex_q;
    unique case (sel)
      SEL_HOLD: begin
        if (rs_hit) ex_d.rs_data = wb_reg_data;
        if (rt_hit) ex_d.rt_data = wb_reg_data;
      end
      SEL_BUBBLE: ex_d = '0;
      SEL_LOAD:   ex_d = id_b;
      default:    ex_d = ex_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_bubbles <= '0;
    end else if (sel == SEL_BUBBLE
                 && perf_bubbles != '1) begin
      perf_bubbles <= perf_bubbles + 1'b1;
    end
  end

  assign bus.ex_valid      = ex_q.valid;
  assign bus.ex_rs         = ex_q.rs;
  assign bus.ex_rt         = ex_q.rt;
  assign bus.ex_rd         = ex_q.rd;
  assign bus.ex_rs_data    = ex_q.rs_data;
  assign bus.ex_rt_data    = ex_q.rt_data;
  assign bus.ex_imm        = ex_q.imm;
  assign bus.ex_alu_op     = ex_q.alu_op;
  assign bus.ex_write_reg  = ex_q.write_reg;
  assign bus.ex_mem_read   = ex_q.mem_read;
  assign bus.ex_mem_write  = ex_q.mem_write;
  assign bus.ex_mem_to_reg = ex_q.mem_to_reg;

endmodule
